yk_adc_sampler: RTL and testbench
=================================

Name: yk_adc_sampler

Overview:
- Produces the plant measurement `yk` and the `compute` strobe consumed by the error/PID stage of the servo loop.
- On a fixed sample period it runs one read frame on an external 8-bit serial ADC (ADC081S021-style: CS, SCLK, SDATA).
- Converts the unsigned code to a signed 9-bit `yk` by subtracting an offset.
- Pulses `compute` for one clock when the new `yk` is valid.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles (≥1).
- SAMPLE_PERIOD, 1000: clk cycles between sample ticks (≥2).
- LEAD_BITS, 3: frame bits ignored before the data MSB.
- OFFSET, 128: value subtracted from the ADC code (0..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sampling enable.
- clr_ovr  in  1  synchronous clear of `overrun`.
- adc_sdata  in  1  ADC serial data, MSB first.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock, idles high.
- yk  out  9  signed measurement, two's complement.
- compute  out  1  one-cycle strobe: `yk` just updated.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (rst=0, async, takes effect immediately, including mid-frame):
  - adc_cs_n=1, adc_sclk=1, yk=0, compute=0, busy=0, overrun=0.
  - FSM=IDLE; all counters and the shift register cleared.
  - An aborted frame produces no compute.
- Tick counter:
  - Counts 0..SAMPLE_PERIOD-1 while en=1, then wraps.
  - Held at 0 while en=0.
  - tick=1 in the cycle the counter equals SAMPLE_PERIOD-1 and en=1.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - tick → SETUP.
  - adc_cs_n goes low in the next cycle (call the tick cycle T).
  - busy=1 from T+1.
- SETUP: cs_n low, sclk high for CLK_DIV cycles → SHIFT.
- SHIFT: 16 SCLK periods.
  - Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
  - adc_sdata is sampled in the clk cycle sclk goes 0→1.
  - Rising edges are indexed 0..15.
  - Edges LEAD_BITS..LEAD_BITS+7 shift into the 8-bit code, MSB first; all other bits are ignored.
  - After the 16th high half → HOLD.
- HOLD: cs_n low, sclk high for CLK_DIV cycles → DONE.
- Frame timing: adc_cs_n is low for exactly 34*CLK_DIV cycles, cycles T+1..T+34*CLK_DIV.
- DONE (cycle T+34*CLK_DIV+1):
  - adc_cs_n=1.
  - yk <= {1'b0,code} - OFFSET (9-bit signed; cannot overflow for OFFSET 0..255).
  - compute=1 for this cycle only; busy=0; → IDLE.
  - Latency tick→compute = 34*CLK_DIV+1 (137 at defaults).
- yk holds its value between DONE cycles.
- Overrun:
  - A tick while FSM≠IDLE is dropped (never queued) and sets overrun.
  - clr_ovr clears it.
  - If clr_ovr and a dropped tick occur in the same cycle, set wins.
  - No overrun is possible when SAMPLE_PERIOD ≥ 34*CLK_DIV+2.
- en deasserted mid-frame: the frame completes normally (compute still pulses); no further ticks.
- en re-asserted: the first tick comes SAMPLE_PERIOD-1 cycles later.
- adc_sclk and adc_cs_n are driven directly from flops (glitch-free).

Test Plan:
- Reset check: hold rst=0, toggle inputs → cs_n=1, sclk=1, yk=0, compute=0, busy=0, overrun=0.
- Single frame, ADC model returns code 0xC8 with lead/trail bits driven 1, defaults:
  - yk=+72 (9'h048).
  - compute is a single pulse at T+137.
  - cs_n low for exactly 136 cycles.
  - Exactly 16 sclk rising edges.
- Code extremes:
  - code 0x00 → yk=-128 (9'h180).
  - code 0xFF → yk=+127 (9'h07F).
  - OFFSET=0, code 0xFF → yk=+255 (9'h0FF).
- Periodic run, en held high 5000 cycles:
  - compute pulses spaced exactly 1000 cycles apart.
  - overrun stays 0.
- Overrun, SAMPLE_PERIOD=100, CLK_DIV=4:
  - The second tick occurs while busy → overrun=1, no overlapping frames.
  - compute spacing 200 cycles.
  - clr_ovr pulse → overrun=0.
- Async reset mid-frame after the 8th sclk rising edge:
  - cs_n and sclk return high within the reset cycle.
  - No compute; yk=0.
  - After release with en=1, the next frame is clean and correct.

Source files
------------

// File: rtl/yk_adc_sampler.sv
// Periodic 8-bit serial ADC reader producing signed yk = code - OFFSET for the servo error stage.
// Latency tick->compute is 34*CLK_DIV+1 clk; a tick during a frame is dropped and flagged in overrun.
module yk_adc_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int LEAD_BITS     = 3,
    parameter int OFFSET        = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr_ovr,
    input  logic              adc_sdata,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic signed [8:0] yk,
    output logic              compute,
    output logic              busy,
    output logic              overrun
);

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [4:0]    LEAD_FIRST = 5'(LEAD_BITS);
    localparam logic [8:0]    OFF9       = 9'(OFFSET);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic [DW-1:0]   div_cnt;
    logic [3:0]      bit_idx;
    logic [7:0]      code;
    logic            tick;
    logic            div_last;
    logic [4:0]      rel_idx;
    logic            in_window;

    assign tick     = en && (tick_cnt == TICK_LAST);
    assign div_last = (div_cnt == DIV_LAST);
    // Frame bits before LEAD_BITS wrap to large values, so one compare selects the data window.
    assign rel_idx   = {1'b0, bit_idx} - LEAD_FIRST;
    assign in_window = (rel_idx < 5'd8);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (!en || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            yk       <= '0;
            compute  <= 1'b0;
            busy     <= 1'b0;
            div_cnt  <= '0;
            bit_idx  <= '0;
            code     <= '0;
        end else begin
            compute <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= SETUP;
                        adc_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        state    <= SHIFT;
                        adc_sclk <= 1'b0;
                        div_cnt  <= '0;
                        bit_idx  <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!div_last) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!adc_sclk) begin
                            // Data is captured on the same edge that raises sclk.
                            adc_sclk <= 1'b1;
                            if (in_window) begin
                                code <= {code[6:0], adc_sdata};
                            end
                        end else if (bit_idx == 4'd15) begin
                            state <= HOLD;
                        end else begin
                            adc_sclk <= 1'b0;
                            bit_idx  <= bit_idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        state    <= DONE;
                        adc_cs_n <= 1'b1;
                        busy     <= 1'b0;
                        compute  <= 1'b1;
                        yk       <= $signed({1'b0, code} - OFF9);
                        div_cnt  <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (tick && (state != IDLE)) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_yk_adc_sampler.sv
// Bench for yk_adc_sampler: default instance (a) and a short-period, zero-offset instance (b).
module tb_yk_adc_sampler;

    localparam int CD   = 4;
    localparam int SPA  = 1000;
    localparam int SPB  = 100;
    localparam int LEAD = 3;
    localparam int OFFA = 128;
    localparam int OFFB = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic              en_a = 1'b0, clr_a = 1'b0, sd_a = 1'b1;
    logic              a_cs_n, a_sclk, a_comp, a_busy, a_ovr;
    logic signed [8:0] a_yk;
    logic              en_b = 1'b0, clr_b = 1'b0, sd_b = 1'b1;
    logic              b_cs_n, b_sclk, b_comp, b_busy, b_ovr;
    logic signed [8:0] b_yk;

    yk_adc_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SPA), .LEAD_BITS(LEAD), .OFFSET(OFFA)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .clr_ovr(clr_a), .adc_sdata(sd_a),
        .adc_cs_n(a_cs_n), .adc_sclk(a_sclk), .yk(a_yk), .compute(a_comp),
        .busy(a_busy), .overrun(a_ovr)
    );

    yk_adc_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SPB), .LEAD_BITS(LEAD), .OFFSET(OFFB)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .clr_ovr(clr_b), .adc_sdata(sd_b),
        .adc_cs_n(b_cs_n), .adc_sclk(b_sclk), .yk(b_yk), .compute(b_comp),
        .busy(b_busy), .overrun(b_ovr)
    );

    // Reference: frame bit e of a 16-bit ADC frame carrying code after LEAD lead bits, 1s elsewhere.
    function automatic logic frame_bit(input logic [7:0] code, input int e);
        if (e >= LEAD && e < LEAD + 8) return code[7 - (e - LEAD)];
        return 1'b1;
    endfunction

    function automatic logic signed [8:0] ref_yk(input logic [7:0] code, input int off);
        int v;
        v = int'(code) - off;
        return 9'(v);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ADC models: next bit presented on cs fall and on every sclk fall.
    logic [7:0] code_a = 8'h00, code_b = 8'h00;
    int a_bit = 0, b_bit = 0;
    always @(posedge a_sclk or posedge a_cs_n) if (a_cs_n) a_bit = 0; else a_bit = a_bit + 1;
    always @(negedge a_cs_n or negedge a_sclk) sd_a = frame_bit(code_a, a_bit);
    always @(posedge b_sclk or posedge b_cs_n) if (b_cs_n) b_bit = 0; else b_bit = b_bit + 1;
    always @(negedge b_cs_n or negedge b_sclk) sd_b = frame_bit(code_b, b_bit);

    // Frame monitors: cs-low length, sclk rising edges per frame, compute cycle numbers.
    int a_len_q[$], a_edge_q[$], a_comp_q[$];
    int b_len_q[$], b_comp_q[$];
    int a_cslen = 0, a_edges = 0, b_cslen = 0;
    logic a_cs_q = 1'b1, a_sclk_q = 1'b1, b_cs_q = 1'b1;

    always @(negedge clk) begin
        if (!a_cs_n) begin
            a_cslen++;
            if (a_sclk && !a_sclk_q) a_edges++;
        end else if (!a_cs_q) begin
            a_len_q.push_back(a_cslen);
            a_edge_q.push_back(a_edges);
            a_cslen = 0;
            a_edges = 0;
        end
        if (a_comp) a_comp_q.push_back(cyc);
        a_cs_q   = a_cs_n;
        a_sclk_q = a_sclk;
        if (!b_cs_n) b_cslen++;
        else if (!b_cs_q) begin
            b_len_q.push_back(b_cslen);
            b_cslen = 0;
        end
        if (b_comp) b_comp_q.push_back(cyc);
        b_cs_q = b_cs_n;
    end

    task automatic clear_a();
        a_len_q.delete();
        a_edge_q.delete();
        a_comp_q.delete();
    endtask

    task automatic run_a(input logic [7:0] code, input string tag);
        int e0, tc;
        bit seen;
        code_a = code;
        clear_a();
        @(negedge clk);
        en_a = 1'b1;
        e0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < SPA + 20; i++) begin
            @(negedge clk);
            if (!a_cs_n) begin seen = 1'b1; break; end
        end
        en_a = 1'b0;
        chk({tag, " frame_start"}, 32'(seen), 1);
        seen = 1'b0;
        tc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_comp) begin seen = 1'b1; tc = cyc; break; end
        end
        chk({tag, " compute_seen"}, 32'(seen), 1);
        chk({tag, " latency"}, tc - e0, SPA + 34 * CD);
        chk({tag, " yk"}, a_yk, ref_yk(code, OFFA));
        @(negedge clk);
        chk({tag, " single_pulse"}, a_comp, 0);
        chk({tag, " busy_after"}, a_busy, 0);
        @(negedge clk);
        chk({tag, " compute_count"}, a_comp_q.size(), 1);
        chk({tag, " cs_len"}, (a_len_q.size() == 1) ? a_len_q[0] : -1, 34 * CD);
        chk({tag, " sclk_edges"}, (a_edge_q.size() == 1) ? a_edge_q[0] : -1, 16);
    endtask

    initial begin
        int e0, e_off, last_acc;
        bit seen, exp_ovr;
        int exp_q[$];

        // Reset held with inputs wiggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en_a  = 1'($urandom_range(0, 1));
            clr_a = 1'($urandom_range(0, 1));
            en_b  = 1'($urandom_range(0, 1));
        end
        chk("rst cs_n", a_cs_n, 1);
        chk("rst sclk", a_sclk, 1);
        chk("rst yk", a_yk, 0);
        chk("rst compute", a_comp, 0);
        chk("rst busy", a_busy, 0);
        chk("rst overrun", a_ovr, 0);
        chk("rst b cs_n", b_cs_n, 1);
        chk("rst b overrun", b_ovr, 0);
        @(negedge clk);
        en_a = 1'b0; clr_a = 1'b0; en_b = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        run_a(8'hC8, "c8");
        run_a(8'h00, "zero");
        run_a(8'hFF, "full");
        for (int k = 0; k < 2; k++) run_a(8'($urandom_range(0, 255)), $sformatf("rand%0d", k));

        // Periodic run: every tick with en high starts a frame.
        code_a = 8'($urandom_range(0, 255));
        clear_a();
        @(negedge clk);
        en_a = 1'b1;
        e0 = cyc;
        repeat (5000) @(negedge clk);
        en_a = 1'b0;
        e_off = cyc;
        repeat (300) @(negedge clk);
        exp_q.delete();
        for (int k = 1; e0 + k * SPA <= e_off; k++) exp_q.push_back(e0 + k * SPA + 34 * CD);
        chk("periodic count", a_comp_q.size(), exp_q.size());
        foreach (exp_q[i])
            chk($sformatf("periodic time%0d", i), (i < a_comp_q.size()) ? a_comp_q[i] : -1, exp_q[i]);
        chk("periodic overrun", a_ovr, 0);
        chk("periodic yk", a_yk, ref_yk(code_a, OFFA));

        // Overrun on the short-period instance, clr held during the first dropped tick.
        code_b = 8'hFF;
        b_len_q.delete();
        b_comp_q.delete();
        clr_b = 1'b1;
        @(negedge clk);
        en_b = 1'b1;
        e0 = cyc;
        repeat (200) @(negedge clk);
        chk("ovr set_wins", b_ovr, 1);
        @(negedge clk);
        chk("ovr held_clr", b_ovr, 0);
        clr_b = 1'b0;
        repeat (249) @(negedge clk);
        en_b = 1'b0;
        e_off = cyc;
        repeat (200) @(negedge clk);
        exp_q.delete();
        last_acc = -100000;
        exp_ovr = 1'b0;
        for (int k = 1; e0 + k * SPB <= e_off; k++) begin
            if (e0 + k * SPB >= last_acc + 34 * CD + 2) begin
                last_acc = e0 + k * SPB;
                exp_q.push_back(last_acc + 34 * CD);
            end else if (e0 + k * SPB > e0 + 201) begin
                exp_ovr = 1'b1;
            end
        end
        chk("ovr count", b_comp_q.size(), exp_q.size());
        foreach (exp_q[i])
            chk($sformatf("ovr time%0d", i), (i < b_comp_q.size()) ? b_comp_q[i] : -1, exp_q[i]);
        foreach (b_len_q[i]) chk($sformatf("ovr cs_len%0d", i), b_len_q[i], 34 * CD);
        chk("ovr flag", b_ovr, 32'(exp_ovr));
        chk("off0 yk", b_yk, ref_yk(8'hFF, OFFB));
        @(negedge clk);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        chk("ovr cleared", b_ovr, 0);

        // Asynchronous reset after the 8th sclk rising edge.
        code_a = 8'h5A;
        clear_a();
        @(negedge clk);
        en_a = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < SPA + 200; i++) begin
            @(negedge clk);
            if (a_edges >= 8) begin seen = 1'b1; break; end
        end
        chk("midrst reached", 32'(seen), 1);
        #2;
        rst = 1'b0;
        en_a = 1'b0;
        #1;
        chk("midrst cs_n", a_cs_n, 1);
        chk("midrst sclk", a_sclk, 1);
        chk("midrst yk", a_yk, 0);
        chk("midrst busy", a_busy, 0);
        clear_a();
        repeat (10) @(negedge clk);
        chk("midrst no_compute", a_comp_q.size(), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_a(8'($urandom_range(0, 255)), "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
